// File: rtl/mole_if.sv
// Whack-a-mole field bus: game enable and player hits in, lit moles and event pulses out.
// master = controller/scoring side, slave = mole_spawner.
interface mole_if #(
  parameter int N_LEDS = 18
);
  logic              enable;
  logic [N_LEDS-1:0] hit_mask;
  logic [N_LEDS-1:0] ledr;
  logic              mole_spawned;
  logic              mole_missed;
  logic [5:0]        moles_up;

  modport master (
    output enable, hit_mask,
    input  ledr, mole_spawned, mole_missed, moles_up
  );

  modport slave (
    input  enable, hit_mask,
    output ledr, mole_spawned, mole_missed, moles_up
  );
endinterface

// File: rtl/mole_spawner.sv
// Mole spawner: lights moles at LFSR-chosen LEDs, ages them out, clears hit moles.
// Ports: clk, rst_n (sync, active-low), bus (mole_if.slave: enable/hit_mask in; ledr/pulses/moles_up out).
module mole_spawner #(
  parameter int          N_LEDS           = 18,
  parameter int          MOLE_LIFE_CYCLES = 50_000_000,
  parameter int          SPAWN_GAP_CYCLES = 25_000_000,
  parameter int          MAX_MOLES        = 3,
  parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
  input logic   clk,
  input logic   rst_n,
  mole_if.slave bus
);
  localparam int LW =
    (MOLE_LIFE_CYCLES > 2) ? $clog2(MOLE_LIFE_CYCLES) : 1;
  localparam int GW =
    (SPAWN_GAP_CYCLES > 1) ? $clog2(SPAWN_GAP_CYCLES) : 1;
  localparam int IW = $clog2(N_LEDS);

  localparam logic [LW-1:0] LIFE_END = LW'(MOLE_LIFE_CYCLES - 1);
  localparam logic [GW-1:0] GAP_END  = GW'(SPAWN_GAP_CYCLES - 1);
  localparam logic [15:0]   TAPS     = 16'hB400;
  localparam logic [15:0]   NL16     = 16'(N_LEDS);
  localparam logic [5:0]    MAX6     = 6'(MAX_MOLES);

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    SPAWN
  } state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [N_LEDS-1:0] ledr_q, ledr_d;
  logic [LW-1:0]     life_q [N_LEDS];
  logic [LW-1:0]     life_d [N_LEDS];
  logic              spawned_q, spawned_d;
  logic              missed_q, missed_d;
  logic [5:0]        up_q, up_d;
  logic [IW-1:0]     idx;

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    lfsr_d    = lfsr_q;
    ledr_d    = ledr_q;
    life_d    = life_q;
    spawned_d = 1'b0;
    missed_d  = 1'b0;
    up_d      = '0;
    idx       = IW'(lfsr_q % NL16);

    if (!bus.enable) begin
      // Field wipe: cleared moles are not misses.
      state_d = IDLE;
      gap_d   = '0;
      ledr_d  = '0;
      for (int i = 0; i < N_LEDS; i++) life_d[i] = '0;
    end else begin
      lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS)
                         : (lfsr_q >> 1);

      for (int i = 0; i < N_LEDS; i++) begin
        if (!ledr_q[i]) begin
          life_d[i] = '0;
        end else if (bus.hit_mask[i]) begin
          ledr_d[i] = 1'b0;
          life_d[i] = '0;
        end else if (life_q[i] == LIFE_END) begin
          ledr_d[i] = 1'b0;
          life_d[i] = '0;
          missed_d  = 1'b1;
        end else begin
          life_d[i] = life_q[i] + 1'b1;
        end
      end

      unique case (state_q)
        IDLE: begin
          state_d = GAP;
          gap_d   = '0;
        end
        GAP: begin
          if (gap_q == GAP_END) begin
            state_d = SPAWN;
            gap_d   = '0;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        SPAWN: begin
          state_d = GAP;
          gap_d   = '0;
          // Occupancy is judged on registered state, so a
          // slot emptying this cycle still blocks the spawn.
          if (!ledr_q[idx] && (up_q < MAX6)) begin
            ledr_d[idx] = 1'b1;
            life_d[idx] = '0;
            spawned_d   = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          gap_d   = '0;
        end
      endcase
    end

    for (int i = 0; i < N_LEDS; i++)
      up_d = up_d + 6'(ledr_d[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gap_q     <= '0;
      lfsr_q    <= LFSR_SEED;
      ledr_q    <= '0;
      spawned_q <= 1'b0;
      missed_q  <= 1'b0;
      up_q      <= '0;
      for (int i = 0; i < N_LEDS; i++) life_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      lfsr_q    <= lfsr_d;
      ledr_q    <= ledr_d;
      spawned_q <= spawned_d;
      missed_q  <= missed_d;
      up_q      <= up_d;
      life_q    <= life_d;
    end
  end

  assign bus.ledr         = ledr_q;
  assign bus.mole_spawned = spawned_q;
  assign bus.mole_missed  = missed_q;
  assign bus.moles_up     = up_q;
endmodule

// File: tb/tb_mole_spawner.sv
// Bench for mole_spawner: directed vector table, corner sequences,
// and random run against an event-level reference model.
module tb_mole_spawner;
  localparam int N = 18;
  localparam int L = 10;
  localparam int G = 4;
  localparam int M = 3;
  localparam int SEED = 'hACE1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mole_if #(.N_LEDS(N)) bus();

  mole_spawner #(
    .N_LEDS(N),
    .MOLE_LIFE_CYCLES(L),
    .SPAWN_GAP_CYCLES(G),
    .MAX_MOLES(M),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  logic [N-1:0] m_lit;
  int m_age [N];
  int m_t;
  bit m_run;
  int m_lfsr;
  bit m_sp, m_ms;

  function automatic int popc(logic [N-1:0] v);
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(v[i]);
    return c;
  endfunction

  function automatic int lfsr_next(int x);
    if (x % 2 == 1) return (x / 2) ^ 'hB400;
    return x / 2;
  endfunction

  task automatic model_edge(bit r, bit en, logic [N-1:0] hit);
    logic [N-1:0] nl;
    int cnt, idx;
    bit spawn_now;
    m_sp = 0;
    m_ms = 0;
    if (!r || !en) begin
      m_lit = '0;
      for (int i = 0; i < N; i++) m_age[i] = 0;
      m_run = 0;
      m_t = 0;
      if (!r) m_lfsr = SEED;
      return;
    end
    cnt = popc(m_lit);
    spawn_now = m_run && (m_t % (G + 1) == G);
    nl = m_lit;
    for (int i = 0; i < N; i++) begin
      if (m_lit[i]) begin
        if (hit[i]) begin
          nl[i] = 0; m_age[i] = 0;
        end else if (m_age[i] == L - 1) begin
          nl[i] = 0; m_age[i] = 0; m_ms = 1;
        end else begin
          m_age[i]++;
        end
      end
    end
    if (spawn_now) begin
      idx = m_lfsr % N;
      if (!m_lit[idx] && cnt < M) begin
        nl[idx] = 1; m_age[idx] = 0; m_sp = 1;
      end
    end
    m_lit = nl;
    if (m_run) m_t++;
    else begin m_run = 1; m_t = 0; end
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  task automatic check(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(bit r, bit en, logic [N-1:0] hit);
    rst_n = r;
    bus.enable = en;
    bus.hit_mask = hit;
    @(posedge clk);
    #1;
    model_edge(r, en, hit);
    check("model_ledr", int'(bus.ledr), int'(m_lit));
    check("model_spawned", int'(bus.mole_spawned), int'(m_sp));
    check("model_missed", int'(bus.mole_missed), int'(m_ms));
    check("model_up", int'(bus.moles_up), popc(m_lit));
  endtask

  typedef struct {
    bit r;
    bit en;
    logic [N-1:0] hit;
    logic [N-1:0] ledr;
    bit sp;
    bit ms;
    int up;
  } vec_t;

  function automatic vec_t mk(bit r, bit en, int hit,
                              int ledr, bit sp, bit ms, int up);
    vec_t v;
    v.r = r; v.en = en; v.hit = N'(hit);
    v.ledr = N'(ledr); v.sp = sp; v.ms = ms; v.up = up;
    return v;
  endfunction

  vec_t tbl[$];
  int first_sp, run5, miss_k, k;
  bit seen5, done5;
  logic [N-1:0] h;

  initial begin
    bus.enable = 0;
    bus.hit_mask = '0;
    m_lit = '0;
    m_lfsr = SEED;
    m_run = 0;
    m_t = 0;
    for (int i = 0; i < N; i++) m_age[i] = 0;

    // Seed 0xACE1: first SPAWN sees lfsr 0x0E27 -> idx 5,
    // second sees 0x30B1 -> idx 9.
    tbl.push_back(mk(0, 0, 0,         0,     0, 0, 0));
    tbl.push_back(mk(1, 1, 0,         0,     0, 0, 0));
    tbl.push_back(mk(1, 1, 0,         0,     0, 0, 0));
    tbl.push_back(mk(1, 1, 0,         0,     0, 0, 0));
    tbl.push_back(mk(1, 1, 0,         0,     0, 0, 0));
    tbl.push_back(mk(1, 1, 0,         0,     0, 0, 0));
    tbl.push_back(mk(1, 1, 0,         'h20,  1, 0, 1));
    tbl.push_back(mk(1, 1, 'h8,       'h20,  0, 0, 1));
    tbl.push_back(mk(1, 1, 0,         'h20,  0, 0, 1));
    tbl.push_back(mk(1, 1, 0,         'h20,  0, 0, 1));
    tbl.push_back(mk(1, 1, 'h20,      0,     0, 0, 0));
    tbl.push_back(mk(1, 1, 0,         'h200, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0,         0,     0, 0, 0));
    tbl.push_back(mk(1, 0, 0,         0,     0, 0, 0));

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].en, tbl[i].hit);
      check($sformatf("tbl%0d_ledr", i), int'(bus.ledr), int'(tbl[i].ledr));
      check($sformatf("tbl%0d_sp", i), int'(bus.mole_spawned), int'(tbl[i].sp));
      check($sformatf("tbl%0d_ms", i), int'(bus.mole_missed), int'(tbl[i].ms));
      check($sformatf("tbl%0d_up", i), int'(bus.moles_up), tbl[i].up);
    end

    // Unhit mole lives exactly L clocks, then one miss pulse.
    step(0, 0, '0);
    first_sp = -1; run5 = 0; miss_k = -1; seen5 = 0; done5 = 0;
    for (k = 0; k < 40; k++) begin
      step(1, 1, '0);
      if (bus.mole_spawned && first_sp < 0) first_sp = k;
      if (bus.mole_missed && miss_k < 0) miss_k = k;
      if (bus.ledr[5] && !done5) begin seen5 = 1; run5++; end
      if (!bus.ledr[5] && seen5) done5 = 1;
    end
    check("first_spawn_k", first_sp, 5);
    check("bit5_life", run5, L);
    check("first_miss_k", miss_k, 15);

    // Hit on the expiry cycle wins: no miss.
    step(0, 0, '0);
    for (k = 0; k < 15; k++) step(1, 1, '0);
    check("pre_hit_bit5", int'(bus.ledr[5]), 1);
    step(1, 1, N'('h20));
    check("hit_last_bit5", int'(bus.ledr[5]), 0);
    check("hit_last_miss", int'(bus.mole_missed), 0);

    // Disable with two moles up.
    step(0, 0, '0);
    k = 0;
    while (popc(bus.ledr) < 2 && k < 50) begin
      step(1, 1, '0);
      k++;
    end
    check("two_up_reached", int'(popc(bus.ledr) >= 2), 1);
    step(1, 0, '0);
    check("dis_ledr", int'(bus.ledr), 0);
    check("dis_up", int'(bus.moles_up), 0);
    check("dis_pulses", int'(bus.mole_spawned | bus.mole_missed), 0);

    // Reset mid-GAP restores the seed: same first mole again.
    step(1, 1, '0);
    step(1, 1, '0);
    step(0, 1, '0);
    check("rst_ledr", int'(bus.ledr), 0);
    check("rst_up", int'(bus.moles_up), 0);
    for (k = 0; k < 6; k++) step(1, 1, '0);
    check("rst_reseed_ledr", int'(bus.ledr), 'h20);

    // Random run against the model.
    for (int c = 0; c < 3000; c++) begin
      h = '0;
      if ($urandom_range(3) == 0)
        h = N'($urandom & $urandom & $urandom);
      step(($urandom_range(400) != 0), ($urandom_range(150) != 0), h);
      check("rand_up_le_max", int'(bus.moles_up <= 6'(M)), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
